// File: rtl/dram_responder.sv
// Single-bank DRAM command responder: ACT/READ/WRITE/PRE decode, tRCD gating,
// a CAS_LAT-deep read pipeline and a sticky protocol-violation flag.
module dram_responder #(
  parameter int ROW_BITS = 6,
  parameter int COL_BITS = 6,
  parameter int CAS_LAT  = 2,
  parameter int T_RCD    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CSn,
  input  logic        RASn,
  input  logic        CASn,
  input  logic [3:0]  WEn,
  input  logic [12:0] A,
  input  logic [31:0] D,
  output logic [31:0] Q,
  output logic        q_valid,
  output logic        err,
  input  logic        err_clr,
  output logic        dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  localparam int AW    = ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << AW;

  logic [31:0] mem_q [DEPTH];

  state_t              state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [2:0]          rcd_q, rcd_d;
  logic                err_q, err_d;
  logic [CAS_LAT-1:0]  vld_q, vld_d;
  logic [31:0]         dat_q [CAS_LAT];
  logic [31:0]         dat_d [CAS_LAT];

  logic          cmd_act, cmd_rd, cmd_wr, cmd_pre;
  logic          rw_ok, rd_ok, wr_ok, viol;
  logic [AW-1:0] addr;
  logic          unused_a;

  assign cmd_act = !CSn && !RASn &&  CASn;
  assign cmd_pre = !CSn && !RASn && !CASn;
  assign cmd_rd  = !CSn &&  RASn && !CASn && (WEn == 4'hF);
  assign cmd_wr  = !CSn &&  RASn && !CASn && (WEn != 4'hF);

  assign rw_ok = (state_q == S_ACTIVE) && (rcd_q == 3'd0);
  assign rd_ok = cmd_rd && rw_ok;
  assign wr_ok = cmd_wr && rw_ok;
  assign viol  = (cmd_act && state_q == S_ACTIVE) || ((cmd_rd || cmd_wr) && !rw_ok);
  assign addr  = {row_q, A[COL_BITS-1:0]};

  assign unused_a = ^A;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rcd_d   = (rcd_q != 3'd0) ? rcd_q - 3'd1 : 3'd0;
    err_d   = err_clr ? 1'b0 : err_q;
    if (viol) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_act) begin
          state_d = S_ACTIVE;
          row_d   = A[ROW_BITS-1:0];
          // Counter holds cycles still to wait after the ACT cycle itself.
          rcd_d   = 3'(T_RCD - 1);
        end
      end
      S_ACTIVE: begin
        if (cmd_pre) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Each stage holds its data unless a valid word moves in, so Q holds between reads.
    vld_d[0] = rd_ok;
    dat_d[0] = rd_ok ? mem_q[addr] : dat_q[0];
    for (int i = 1; i < CAS_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      rcd_q   <= 3'd0;
      err_q   <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < CAS_LAT; i++) dat_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rcd_q   <= rcd_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      for (int i = 0; i < CAS_LAT; i++) dat_q[i] <= dat_d[i];
    end
  end

  // Storage survives reset; no write can occur while reset holds state in IDLE.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (!WEn[k]) mem_q[addr][8*k +: 8] <= D[8*k +: 8];
      end
    end
  end

  assign Q         = dat_q[CAS_LAT-1];
  assign q_valid   = vld_q[CAS_LAT-1];
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder (default parameters: CAS_LAT=2, T_RCD=2).
module tb_dram_responder;

  logic        clk;
  logic        rst;
  logic        CSn, RASn, CASn;
  logic [3:0]  WEn;
  logic [12:0] A;
  logic [31:0] D;
  logic [31:0] Q;
  logic        q_valid;
  logic        err;
  logic        err_clr;
  logic        dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  dram_responder dut (
    .clk(clk), .rst(rst), .CSn(CSn), .RASn(RASn), .CASn(CASn), .WEn(WEn),
    .A(A), .D(D), .Q(Q), .q_valid(q_valid), .err(err), .err_clr(err_clr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: present one command for one cycle, return 1ns after the capturing edge
  task automatic cmd(input logic cs, input logic ras, input logic cas, input logic [3:0] we,
                     input logic [12:0] a, input logic [31:0] d, input logic clr);
    CSn = cs; RASn = ras; CASn = cas; WEn = we; A = a; D = d; err_clr = clr;
    @(posedge clk);
    #1;
    CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF; err_clr = 1'b0;
  endtask

  task automatic nop();                          cmd(1'b1, 1'b1, 1'b1, 4'hF, 13'h0, 32'h0, 1'b0); endtask
  task automatic act(input logic [12:0] row);    cmd(1'b0, 1'b0, 1'b1, 4'hF, row, 32'h0, 1'b0);   endtask
  task automatic pre();                          cmd(1'b0, 1'b0, 1'b0, 4'hF, 13'h0, 32'h0, 1'b0); endtask
  task automatic rd(input logic [12:0] col);     cmd(1'b0, 1'b1, 1'b0, 4'hF, col, 32'h0, 1'b0);   endtask
  task automatic wr(input logic [12:0] col, input logic [31:0] d, input logic [3:0] we);
    cmd(1'b0, 1'b1, 1'b0, we, col, d, 1'b0);
  endtask

  // scoreboard helper: expect a read result in the current cycle
  task automatic expect_read(input string tag);
    logic [31:0] e;
    check({tag, "_valid"}, {31'b0, q_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, Q, e);
    end
  endtask

  initial begin
    CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF; A = '0; D = '0; err_clr = 1'b0;
    rst = 1'b0;
    #23;
    check("rst_q", Q, 32'h0);
    check("rst_qv", {31'b0, q_valid}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_state", {31'b0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // ACT t0, WRITE t2, READ t3 (upper address bits set, ignored), data at t5
    act(13'd3);
    check("act_state", {31'b0, dbg_state}, 32'd1);
    nop();
    wr(13'd5, 32'hDEADBEEF, 4'h0);
    rd(13'h1FC5);
    exp_q.push_back(32'hDEADBEEF);
    check("lat_t4_qv", {31'b0, q_valid}, 32'd0);
    nop();
    expect_read("lat_t5");
    check("lat_err", {31'b0, err}, 32'd0);
    nop();
    check("hold_qv", {31'b0, q_valid}, 32'd0);
    check("hold_q", Q, 32'hDEADBEEF);

    // byte-lane write mask
    wr(13'd6, 32'h11223344, 4'h0);
    wr(13'd6, 32'hAABBCCDD, 4'b1010);
    rd(13'd6);
    exp_q.push_back(32'h11BB33DD);
    nop();
    expect_read("mask");

    // back-to-back reads, one per cycle
    for (int i = 0; i < 4; i++) wr(13'(i), 32'(i), 4'h0);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        rd(13'(i));
        exp_q.push_back(32'(i));
      end else begin
        nop();
      end
      if (i >= 1 && i <= 4) expect_read($sformatf("b2b%0d", i - 1));
      else check($sformatf("b2b_gap%0d", i), {31'b0, q_valid}, 32'd0);
    end

    // ACT while active: ignored, err set, open row unchanged
    act(13'd4);
    check("actact_err", {31'b0, err}, 32'd1);
    rd(13'd5);
    exp_q.push_back(32'hDEADBEEF);
    nop();
    expect_read("actact_row");
    cmd(1'b1, 1'b1, 1'b1, 4'hF, 13'h0, 32'h0, 1'b1);
    check("clr_err", {31'b0, err}, 32'd0);

    // READ too soon after ACT
    pre();
    check("pre_state", {31'b0, dbg_state}, 32'd0);
    pre();
    check("pre_idle_err", {31'b0, err}, 32'd0);
    act(13'd3);
    rd(13'd5);
    check("rcd_err", {31'b0, err}, 32'd1);
    nop();
    check("rcd_noqv1", {31'b0, q_valid}, 32'd0);
    nop();
    check("rcd_noqv2", {31'b0, q_valid}, 32'd0);
    // violation in the clear cycle keeps err set
    cmd(1'b0, 1'b0, 1'b1, 4'hF, 13'd7, 32'h0, 1'b1);
    check("clr_viol_err", {31'b0, err}, 32'd1);
    cmd(1'b1, 1'b1, 1'b1, 4'hF, 13'h0, 32'h0, 1'b1);
    check("clr2_err", {31'b0, err}, 32'd0);

    // row isolation, read completing across PRE
    pre();
    act(13'd1); nop();
    wr(13'd0, 32'hCAFE0001, 4'h0);
    pre();
    act(13'd2); nop();
    wr(13'd0, 32'h12345678, 4'h0);
    rd(13'd0);
    exp_q.push_back(32'h12345678);
    pre();
    expect_read("row2_after_pre");
    act(13'd1); nop();
    rd(13'd0);
    exp_q.push_back(32'hCAFE0001);
    nop();
    expect_read("row1_kept");

    // reset with a read in flight
    rd(13'd0);
    #4;
    rst = 1'b0;
    #1;
    check("mrst_q", Q, 32'h0);
    check("mrst_qv", {31'b0, q_valid}, 32'd0);
    check("mrst_state", {31'b0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    nop();
    check("mrst_noqv1", {31'b0, q_valid}, 32'd0);
    nop();
    check("mrst_noqv2", {31'b0, q_valid}, 32'd0);
    rd(13'd0);
    check("mrst_rd_err", {31'b0, err}, 32'd1);
    act(13'd1); nop();
    rd(13'd0);
    exp_q.push_back(32'hCAFE0001);
    nop();
    expect_read("mrst_retain");
    nop();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
